score_display: RTL
==================

SCORE_DISPLAY -- requirements
Module: score_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, meaning clock cycles each digit is driven before the scan advances (legal range 2..2^20).
REQ-002 SHALL have port clk  input  1  the single clock, which is the same slow game clock that advances score.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port score  input  16  unsigned binary game score from the game controller.
REQ-005 SHALL have port an  output  4  anode enables, active-low; an[0] is the units digit and an[3] is the thousands digit.
REQ-006 SHALL have port ssd  output  7  cathodes {g,f,e,d,c,b,a}, active-low.
REQ-007 SHALL have port dp  output  1  decimal point, active-low; it is held at 1 (off).
REQ-008 SHALL have port busy  output  1  high while a binary-to-BCD conversion is in progress.

Function
REQ-009 SHALL implement a conversion FSM with the states IDLE, CONV and LOAD.
REQ-010 SHALL, in IDLE, start a conversion when score differs from last_val or when first_done is 0: latch min(score, 9999) into the shift register, latch score into last_val, clear the BCD register, and enter CONV.
REQ-011 SHALL, in CONV, perform one double-dabble step per cycle: add 3 to each BCD nibble that is ≥5, then shift {bcd, bin} left by 1; this repeats for exactly 16 cycles using a 5-bit step counter.
REQ-012 SHALL, in LOAD, copy the 16-bit BCD result into the display register, set first_done to 1, and return to IDLE.
REQ-013 SHALL update the display register 18 cycles after the IDLE cycle that samples a changed score (1 latch + 16 shift + 1 load).
REQ-014 SHALL ignore score changes that occur during CONV or LOAD; the comparison made in the next IDLE cycle retriggers the conversion, so the final value is always displayed.
REQ-015 SHALL clamp scores above 9999 so the display shows 9999; for example, 65535 displays as 9999.
REQ-016 SHALL drive busy = 1 exactly in CONV and LOAD.
REQ-017 SHALL advance the scan every SCAN_DIV cycles: the prescaler counts 0..SCAN_DIV-1, and on its wrap the digit index advances 0→1→2→3→0.
REQ-018 SHALL drive an low only at the position given by the digit index; all other positions are high.
REQ-019 SHALL blank leading zeros: digit k is blanked (ssd = 1111111) when k>0 and every display digit at position ≥k is 0; the units digit is never blanked.
REQ-020 SHALL decode digit values 0–9 to the standard 7-segment patterns; the BCD values 10–15 are unreachable and SHALL decode to blank.
REQ-021 SHALL register an and ssd, so the outputs change one cycle after the digit index changes.

Reset
REQ-022 SHALL, while rst is high, force: state IDLE, display register 0, last_val 0, first_done 0, prescaler 0, digit index 0, an 1111, ssd 1111111, dp 1, busy 0.
REQ-023 SHALL discard any conversion in progress when rst asserts mid-conversion; after release, a fresh conversion of the current score starts in the first IDLE cycle.

Structure
REQ-024 SHALL place in a shared package: the FSM state encodings, the active-low segment constants for digits 0–9 and blank, the digit count (4), and the clamp value 9999.
REQ-025 SHALL instantiate one sub-module, bcd_to_7seg, a combinational decoder that maps 4-bit BCD plus a blank flag to a 7-bit active-low segment value.
REQ-026 SHALL keep the conversion FSM and the scan logic as independent always-blocks within score_display.

Verification (benches use SCAN_DIV=4)
REQ-027 SHALL cover: reset, then score=0 → after 18 cycles the display register is 0000, and the scan shows an=1110 ssd=1000000 with an 0111/1011/1101 blanked.
REQ-028 SHALL cover: score=1234 held → busy high for 17 cycles, and the four an positions then show 1,2,3,4 (ssd 1111001, 0100100, 0110000, 0011001).
REQ-029 SHALL cover: score=42 → the thousands and hundreds digits are blank, the tens digit is 0011001 and the units digit is 0100100.
REQ-030 SHALL cover: score=65535 → every digit shows 9 (0010000).
REQ-031 SHALL cover: score stepping 7→8 on cycle 5 of a conversion → the display shows 7 first, then 8 no later than 36 cycles after the first change.
REQ-032 SHALL cover: rst pulsed at step 10 of a conversion of 5000 → outputs hold their reset values during the pulse, and 5000 is shown 18 cycles after release.

Source files
------------

// File: rtl/score_display_pkg.sv
// Shared types and constants for the score display: FSM states, segment patterns, sizes.
package score_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_LOAD = 2'd2
    } state_t;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned SCORE_W    = 16;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned STEP_W     = 5;

    localparam logic [SCORE_W-1:0] CLAMP_VAL = 16'd9999;

    // Active-low cathodes {g,f,e,d,c,b,a}
    localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/score_display_bcd_to_7seg.sv
// Combinational BCD digit to active-low 7-segment decoder with blanking.
module bcd_to_7seg
    import score_display_pkg::*;
(
    input  logic [DIGIT_W-1:0] bcd,
    input  logic               blank,
    output logic [SEG_W-1:0]   seg_c
);

    // Decode one digit; non-decimal codes and blanked digits show nothing
    always_comb begin
        seg_c = SEG_BLANK;
        if (!blank) begin
            case (bcd)
                4'd0:    seg_c = SEG_0;
                4'd1:    seg_c = SEG_1;
                4'd2:    seg_c = SEG_2;
                4'd3:    seg_c = SEG_3;
                4'd4:    seg_c = SEG_4;
                4'd5:    seg_c = SEG_5;
                4'd6:    seg_c = SEG_6;
                4'd7:    seg_c = SEG_7;
                4'd8:    seg_c = SEG_8;
                4'd9:    seg_c = SEG_9;
                default: seg_c = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/score_display.sv
// Four-digit multiplexed score display: binary-to-BCD conversion FSM plus digit scanner.
module score_display
    import score_display_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SCORE_W-1:0] score,
    output logic [NUM_DIGITS-1:0] an,
    output logic [SEG_W-1:0]   ssd,
    output logic               dp,
    output logic               busy
);

    localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
    localparam int unsigned BCD_W = NUM_DIGITS * DIGIT_W;
    localparam logic [STEP_W-1:0] LAST_STEP = 5'd15;

    state_t              state, state_nxt;
    logic [SCORE_W-1:0]  bin, bin_nxt;
    logic [BCD_W-1:0]    bcd, bcd_nxt, bcd_adj;
    logic [STEP_W-1:0]   step, step_nxt;
    logic [BCD_W-1:0]    disp, disp_nxt;
    logic [SCORE_W-1:0]  last_val, last_val_nxt;
    logic                first_done, first_done_nxt;

    logic [PRE_W-1:0]    pre;
    logic [IDX_W-1:0]    idx;
    logic [DIGIT_W-1:0]  digit_c;
    logic                blank_c;
    logic [SEG_W-1:0]    seg_c;

    assign dp = 1'b1;

    // Conversion FSM: next state and datapath updates (double-dabble, one step per cycle)
    always_comb begin
        state_nxt      = state;
        bin_nxt        = bin;
        bcd_nxt        = bcd;
        step_nxt       = step;
        disp_nxt       = disp;
        last_val_nxt   = last_val;
        first_done_nxt = first_done;
        bcd_adj        = bcd;
        for (int unsigned n = 0; n < NUM_DIGITS; n++) begin
            if (bcd[n*DIGIT_W +: DIGIT_W] >= 4'd5)
                bcd_adj[n*DIGIT_W +: DIGIT_W] = bcd[n*DIGIT_W +: DIGIT_W] + 4'd3;
        end
        case (state)
            ST_IDLE: begin
                if ((score != last_val) || !first_done) begin
                    bin_nxt      = (score > CLAMP_VAL) ? CLAMP_VAL : score;
                    last_val_nxt = score;
                    bcd_nxt      = '0;
                    step_nxt     = '0;
                    state_nxt    = ST_CONV;
                end
            end
            ST_CONV: begin
                {bcd_nxt, bin_nxt} = {bcd_adj, bin} << 1;
                step_nxt = step + 5'd1;
                if (step == LAST_STEP)
                    state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                disp_nxt       = bcd;
                first_done_nxt = 1'b1;
                state_nxt      = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Conversion FSM state and datapath registers; reset discards any conversion in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            bin        <= '0;
            bcd        <= '0;
            step       <= '0;
            disp       <= '0;
            last_val   <= '0;
            first_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            bin        <= bin_nxt;
            bcd        <= bcd_nxt;
            step       <= step_nxt;
            disp       <= disp_nxt;
            last_val   <= last_val_nxt;
            first_done <= first_done_nxt;
            busy       <= (state_nxt != ST_IDLE);
        end
    end

    // Scan prescaler and digit index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre <= '0;
            idx <= '0;
        end else if (pre == PRE_W'(SCAN_DIV - 1)) begin
            pre <= '0;
            idx <= idx + IDX_W'(1);
        end else begin
            pre <= pre + PRE_W'(1);
        end
    end

    // Select the scanned digit and blank it if it is a leading zero
    always_comb begin
        digit_c = '0;
        blank_c = (idx != '0);
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (IDX_W'(k) == idx)
                digit_c = disp[k*DIGIT_W +: DIGIT_W];
            if ((IDX_W'(k) >= idx) && (disp[k*DIGIT_W +: DIGIT_W] != '0))
                blank_c = 1'b0;
        end
    end

    bcd_to_7seg u_dec (
        .bcd   (digit_c),
        .blank (blank_c),
        .seg_c (seg_c)
    );

    // Registered anode and cathode drive
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= '1;
            ssd <= SEG_BLANK;
        end else begin
            an  <= ~(NUM_DIGITS'(1) << idx);
            ssd <= seg_c;
        end
    end

endmodule
